// File: rtl/adder_tree_seq_ctrl_pkg.sv
// Shared types and default sizing for the adder tree sequencer.
`timescale 1ns/1ps
package adder_tree_seq_ctrl_pkg;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DEF_ROW_W    = 4;
   localparam int DEF_SUM_W    = 12;
   localparam int DEF_PIPE_LAT = 3;

   // At most 2^row_w - 1 sums of sum_w bits each, so sum_w + row_w bits never overflow.
   function automatic int acc_w(input int sum_w, input int row_w);
      return sum_w + row_w;
   endfunction

endpackage

// File: rtl/adder_tree_lat_tracker.sv
// Follows each row read through the bank read and adder tree pipeline, and counts the sums returned.
`timescale 1ns/1ps
module adder_tree_lat_tracker
   import adder_tree_seq_ctrl_pkg::*;
#(
   parameter int PIPE_LAT = DEF_PIPE_LAT,
   parameter int ROW_W    = DEF_ROW_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             rd_en,
   output logic             tail_valid,
   output logic [ROW_W-1:0] ret_cnt
);

   logic [PIPE_LAT-1:0] vld_q, vld_d;
   logic [ROW_W-1:0]    ret_cnt_q, ret_cnt_d;

   // Shift the read strobe toward the tail, and count each sum as it leaves the pipeline.
   always_comb begin
      // NOTE: give every signal a default before any branch; otherwise a path that skips it infers a latch.
      vld_d     = vld_q;
      ret_cnt_d = ret_cnt_q;
      vld_d[0]  = rd_en;
      for (int i = 1; i < PIPE_LAT; i++) vld_d[i] = vld_q[i-1];
      if (vld_q[PIPE_LAT-1]) ret_cnt_d = ret_cnt_q + ROW_W'(1);
      if (clr) begin
         vld_d     = '0;
         ret_cnt_d = '0;
      end
   end

   // Pipeline and counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q     <= '0;
         ret_cnt_q <= '0;
      end else begin
         // NOTE: use non-blocking assignments in clocked blocks so every flop samples pre-edge values.
         vld_q     <= vld_d;
         ret_cnt_q <= ret_cnt_d;
      end
   end

   assign tail_valid = vld_q[PIPE_LAT-1];
   assign ret_cnt    = ret_cnt_q;

endmodule

// File: rtl/adder_tree_seq_ctrl.sv
// Issues a job of row reads to the bank memory, accumulates the returned adder tree sums, and
// presents the total on a valid/ready port.
`timescale 1ns/1ps
module adder_tree_seq_ctrl
   import adder_tree_seq_ctrl_pkg::*;
#(
   parameter  int ROW_W    = DEF_ROW_W,
   parameter  int SUM_W    = DEF_SUM_W,
   parameter  int PIPE_LAT = DEF_PIPE_LAT,
   localparam int ACC_W    = acc_w(SUM_W, ROW_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [ROW_W-1:0] num_rows,
   input  logic [ROW_W-1:0] base_addr,
   output logic             busy,
   output logic             rd_en,
   output logic [ROW_W-1:0] rd_addr,
   input  logic [SUM_W-1:0] tree_sum,
   output logic [ACC_W-1:0] res_data,
   output logic             res_valid,
   input  logic             res_ready
);

   state_e           state_q, state_d;
   logic [ROW_W-1:0] num_rows_q, num_rows_d;
   logic [ROW_W-1:0] addr_q, addr_d;
   logic [ROW_W-1:0] issued_q, issued_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] res_data_q, res_data_d;
   logic             clr;
   logic             tail_valid;
   logic [ROW_W-1:0] ret_cnt;

   adder_tree_lat_tracker #(
      .PIPE_LAT (PIPE_LAT),
      .ROW_W    (ROW_W)
   ) u_lat_tracker (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .rd_en      (rd_en),
      .tail_valid (tail_valid),
      .ret_cnt    (ret_cnt)
   );

   // Next-state logic: job launch, back-to-back row issue, drain of in-flight sums, result hold.
   always_comb begin
      state_d    = state_q;
      num_rows_d = num_rows_q;
      addr_d     = addr_q;
      issued_d   = issued_q;
      acc_d      = acc_q;
      res_data_d = res_data_q;
      clr        = 1'b0;
      if (tail_valid) acc_d = acc_q + ACC_W'(tree_sum);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               clr        = 1'b1;
               acc_d      = '0;
               num_rows_d = num_rows;
               addr_d     = base_addr;
               issued_d   = '0;
               if (num_rows != '0) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d    = ST_DONE;
                  res_data_d = '0;
               end
            end
         end
         ST_ISSUE: begin
            addr_d   = addr_q + ROW_W'(1);   // wraps modulo 2^ROW_W
            issued_d = issued_q + ROW_W'(1);
            if (issued_q == num_rows_q - ROW_W'(1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // The final sum always arrives here, since it comes at least one cycle after the last read.
            if (tail_valid && (ret_cnt + ROW_W'(1) == num_rows_q)) begin
               state_d    = ST_DONE;
               res_data_d = acc_d;
            end
         end
         ST_DONE: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, job and accumulator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         num_rows_q <= '0;
         addr_q     <= '0;
         issued_q   <= '0;
         acc_q      <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         num_rows_q <= num_rows_d;
         addr_q     <= addr_d;
         issued_q   <= issued_d;
         acc_q      <= acc_d;
         res_data_q <= res_data_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign rd_en     = (state_q == ST_ISSUE);
   assign rd_addr   = addr_q;
   assign res_valid = (state_q == ST_DONE);
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_adder_tree_seq_ctrl.sv
// Self-checking bench for adder_tree_seq_ctrl: directed and random jobs against a job-level model.
`timescale 1ns/1ps
module tb_adder_tree_seq_ctrl;

   localparam int ROW_W    = 4;
   localparam int SUM_W    = 12;
   localparam int PIPE_LAT = 3;
   localparam int ACC_W    = SUM_W + ROW_W;
   localparam int NROWS    = 1 << ROW_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [ROW_W-1:0] num_rows = '0;
   logic [ROW_W-1:0] base_addr = '0;
   logic             busy;
   logic             rd_en;
   logic [ROW_W-1:0] rd_addr;
   logic [SUM_W-1:0] tree_sum = '0;
   logic [ACC_W-1:0] res_data;
   logic             res_valid;
   logic             res_ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   adder_tree_seq_ctrl #(
      .ROW_W    (ROW_W),
      .SUM_W    (SUM_W),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_rows  (num_rows),
      .base_addr (base_addr),
      .busy      (busy),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .tree_sum  (tree_sum),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
      end
   endtask

   // One job, starting at a negedge with start driven for the accept cycle.
   // fixed: >=0 constant sum, -1 random sums, -2 sums 100,200,300,...
   // ready_delay: 0 keeps res_ready high throughout; k>0 holds it low for k result cycles.
   task automatic run_job(input int n, input int base, input int fixed,
                          input int ready_delay, input bit stress);
      int vals[$];
      int exp_sum;
      int done_c;
      int idx;
      exp_sum = 0;
      for (int i = 0; i < n; i++) begin
         int v;
         if (fixed >= 0)       v = fixed;
         else if (fixed == -2) v = 100 * (i + 1);
         else                  v = int'($urandom_range(0, (1 << SUM_W) - 1));
         vals.push_back(v);
         exp_sum += v;
      end
      done_c    = (n == 0) ? 1 : n + PIPE_LAT + 1;
      res_ready = (ready_delay == 0);
      start     = 1'b1;
      num_rows  = ROW_W'(n);
      base_addr = ROW_W'(base);
      tree_sum  = SUM_W'($urandom);
      for (int c = 1; c <= done_c; c++) begin
         @(negedge clk);
         check("busy", busy, 1);
         check("rd_en", rd_en, (c <= n));
         if (c <= n) check("rd_addr", rd_addr, (base + c - 1) % NROWS);
         check("res_valid", res_valid, (c == done_c));
         // Row i's sum is presented PIPE_LAT cycles after its read in cycle i+1.
         idx      = c - 1 - PIPE_LAT;
         tree_sum = (idx >= 0 && idx < n) ? SUM_W'(vals[idx]) : SUM_W'($urandom);
         start    = (stress && c > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         num_rows  = ROW_W'($urandom);
         base_addr = ROW_W'($urandom);
      end
      check("res_data", res_data, exp_sum);
      for (int k = 0; k < ready_delay; k++) begin
         start = stress;
         @(negedge clk);
         check("hold_valid", res_valid, 1);
         check("hold_busy", busy, 1);
         check("hold_data", res_data, exp_sum);
      end
      res_ready = 1'b1;
      start     = stress;   // lands in the handshake cycle and must be dropped
      @(negedge clk);
      start = 1'b0;
      check("post_busy", busy, 0);
      check("post_valid", res_valid, 0);
      check("post_data", res_data, exp_sum);
   endtask

   initial begin
      #1;
      check("rst_busy", busy, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_valid", res_valid, 0);
      check("rst_data", res_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic: rows 2,3,4 returning 100,200,300.
      run_job(3, 2, -2, 0, 1'b0);
      // Max rows with wrapping addresses and largest sums.
      run_job(15, 14, 4080, 0, 1'b0);
      // Backpressure with ignored start pulses.
      run_job(5, 9, -1, 10, 1'b1);
      // Zero rows.
      run_job(0, 3, -1, 0, 1'b0);
      // Back-to-back jobs.
      run_job(4, 1, -1, 0, 1'b0);
      run_job(6, 12, -1, 2, 1'b0);

      // Reset in the middle of a job.
      start = 1'b1; num_rows = 4'd8; base_addr = 4'd5;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rd_en", rd_en, 1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_rd_en", rd_en, 0);
      check("arst_rd_addr", rd_addr, 0);
      check("arst_valid", res_valid, 0);
      check("arst_data", res_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tree_sum = SUM_W'($urandom);
         @(negedge clk);
         check("after_rst_valid", res_valid, 0);
         check("after_rst_busy", busy, 0);
      end
      run_job(7, 10, -1, 1, 1'b1);

      // Random jobs.
      for (int j = 0; j < 25; j++) begin
         run_job(int'($urandom_range(0, NROWS - 1)), int'($urandom_range(0, NROWS - 1)),
                 -1, int'($urandom_range(0, 3)), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/adder_tree_seq_ctrl.md
Name: adder_tree_seq_ctrl

Overview:
- Sequencer for the 16-bank, 12-bit-sum pipelined adder tree.
- On a start command, issues a programmed number of bank-row reads, tracks the fixed read+tree pipeline latency, and accumulates each returned tree sum into a wider accumulator.
- Presents the final total on a valid/ready result port.
- Sits between the command source (host/CSR) and the bank memory + adder tree datapath.

Parameters:
- ROW_W, 4, width of row count and row address; max rows per job = 2^ROW_W - 1.
- SUM_W, 12, width of adder tree sum input.
- PIPE_LAT, 3, cycles from rd_en high to matching tree_sum valid (1 bank read + tree input reg + tree output reg); legal range 1..8.
- ACC_W (localparam), SUM_W + ROW_W, accumulator/result width; overflow impossible by construction.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset, no other reset exists
- start  in  1  pulse; launches a job when idle
- num_rows  in  ROW_W  rows to sum; sampled only in the cycle start is accepted
- base_addr  in  ROW_W  first row address; sampled with start
- busy  out  1  high from start-accept cycle until result handshake completes
- rd_en  out  1  bank-row read strobe to all 16 banks
- rd_addr  out  ROW_W  row address for rd_en
- tree_sum  in  SUM_W  adder tree output
- res_data  out  ACC_W  accumulated total
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy=0, rd_en=0, rd_addr=0, res_valid=0, res_data=0. Accumulator, counters and latency shift register cleared. Reset mid-job aborts the job silently; no partial result is output.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 and num_rows!=0 -> ISSUE. Latch num_rows and base_addr; clear accumulator; busy=1 next cycle. start=1 and num_rows==0 -> DONE directly with res_data=0. start=0 -> stay.
- ISSUE:
  - rd_en=1 every cycle; rd_addr = base_addr + issued_count, wrapping modulo 2^ROW_W.
  - After num_rows strobes -> DRAIN.
  - rd_en is back-to-back, one row per cycle, no bubbles.
- Latency tracking: PIPE_LAT-deep shift register of rd_en. When its tail bit is 1, acc <= acc + zero-extended tree_sum in that cycle. Tree_sum is ignored in all other cycles.
- DRAIN: rd_en=0. When the last tail bit has been accumulated (returned count == num_rows) -> DONE.
- DONE:
  - res_valid=1; res_data=acc, held stable while res_ready=0.
  - Handshake completes on res_valid & res_ready. Next cycle: res_valid=0, busy=0, state IDLE.
  - res_ready may be high before res_valid; the result is then accepted in the first DONE cycle.
- start while busy (ISSUE/DRAIN/DONE): ignored, not queued. A start in the handshake-completion cycle is also ignored.
- Job latency, num_rows=N>0: start accepted at edge 0; rd_en cycles 1..N; last accumulate in cycle N+PIPE_LAT; res_valid first high in cycle N+PIPE_LAT+1.
- res_data is not cleared after handshake; it holds until the next job's DONE.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit enum IDLE/ISSUE/DRAIN/DONE).
  - Default ROW_W/SUM_W/PIPE_LAT constants.
  - ACC_W derivation function.
- One natural sub-module: adder_tree_lat_tracker, a parameterized PIPE_LAT valid shift register plus returned-row counter. FSM and accumulator stay in the top.

Test Plan:
- Reset mid-job: start, num_rows=8, rst_n low in cycle 4 -> all outputs 0 immediately (async); after release, no res_valid; new job runs correctly.
- Basic sum: num_rows=3, base_addr=2, tree_sum returns 100,200,300 -> rd_en cycles 1-3 with rd_addr 2,3,4; res_valid in cycle 7; res_data=600.
- Max/wrap: num_rows=15, base_addr=14, tree_sum=4080 every valid cycle:
  - rd_addr sequence 14,15,0,1,...,12.
  - res_data=61200 with no overflow in 16 bits.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> res_data/res_valid stable, busy=1; start pulses in that window ignored; accept on res_ready=1, then busy=0 next cycle.
- Zero rows: start with num_rows=0 -> no rd_en; res_valid next cycle with res_data=0.
- Back-to-back jobs: second start in the first IDLE cycle after handshake -> accepted. Accumulator restarts from 0, so the second result excludes the first job's total.
